// File: rtl/vga_pix_feeder_if.sv
// Pixel-feeder bus bundle: read-side FIFO handshake plus the vga_ctrl
// request/sync/colour signals. The master modport is the feeder itself.
interface vga_pix_feeder_if;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic        fifo_empty;
    logic        pix_req;
    logic        vsync;
    logic [23:0] rgb_out;

    modport master (
        output fifo_rd_en,
        output rgb_out,
        input  fifo_rd_data,
        input  fifo_empty,
        input  pix_req,
        input  vsync
    );

    modport slave (
        input  fifo_rd_en,
        input  rgb_out,
        output fifo_rd_data,
        output fifo_empty,
        output pix_req,
        output vsync
    );
endinterface

// File: rtl/vga_pix_feeder.sv
// Pixel-supply stage ahead of vga_ctrl. Prefetches 64-bit words (two
// pixels each) from a standard read FIFO into a 2-word buffer, unpacks
// them on pix_req, aligns to frame start on the vsync active edge and
// keeps sticky underflow / frame-length error flags.
module vga_pix_feeder #(
    parameter int unsigned FRAME_PIX       = 307200,
    parameter logic        VS_ACTIVE       = 1'b0,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    vga_pix_feeder_if.master  bus,
    output logic              underflow,
    output logic              frame_err
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t      r_state;
    logic [63:0] r_buf0;        // head word
    logic [63:0] r_buf1;
    logic [1:0]  r_cnt;
    logic        r_sel;
    logic        r_rd_pend;
    logic        r_vsync_d;
    logic [19:0] r_pcnt;
    logic [23:0] r_rgb;
    logic        r_underflow;
    logic        r_frame_err;

    logic        w_vs_edge;
    logic        w_rd_en;
    logic        w_run;
    logic        w_serve;
    logic        w_pop;
    logic        w_push;
    logic        w_uf_set;
    logic        w_fe_set;
    logic [23:0] w_pix;

    // Read strobe, serve/pop/push decisions and flag-set events.
    always_comb begin
        w_vs_edge = (bus.vsync == VS_ACTIVE) && (r_vsync_d != VS_ACTIVE);
        w_rd_en   = (r_state != IDLE) && !bus.fifo_empty
                    && (({1'b0, r_cnt} + {2'b00, r_rd_pend}) < 3'd2);
        w_run     = (r_state == RUN) && en;
        w_serve   = w_run && bus.pix_req && (r_cnt != 2'd0);
        w_pop     = w_serve && r_sel;
        // rd_pend is never set in IDLE; en low drops an in-flight word.
        w_push    = r_rd_pend && en;
        w_pix     = r_sel ? r_buf0[55:32] : r_buf0[23:0];
        w_uf_set  = w_run && bus.pix_req && (r_cnt == 2'd0);
        w_fe_set  = w_run && w_vs_edge && (r_pcnt != 20'(FRAME_PIX));
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.rgb_out    = r_rgb;
    assign underflow      = r_underflow;
    assign frame_err      = r_frame_err;

    // Control FSM, prefetch buffer and pixel counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_rd_pend <= 1'b0;
            r_vsync_d <= ~VS_ACTIVE;
            r_pcnt    <= '0;
        end else begin
            r_vsync_d <= bus.vsync;
            if (!en) begin
                r_state   <= IDLE;
                r_buf0    <= '0;
                r_buf1    <= '0;
                r_cnt     <= '0;
                r_sel     <= 1'b0;
                r_rd_pend <= 1'b0;
                r_pcnt    <= '0;
            end else begin
                r_rd_pend <= w_rd_en;

                case (r_state)
                    IDLE: r_state <= FILL;
                    FILL: begin
                        if (w_vs_edge && (r_cnt == 2'd2)) begin
                            r_state <= RUN;
                            r_pcnt  <= '0;
                        end
                    end
                    RUN: begin
                        if (w_vs_edge)
                            r_pcnt <= '0;
                        else if (bus.pix_req && (r_pcnt != '1))
                            r_pcnt <= r_pcnt + 20'd1;
                    end
                    default: r_state <= IDLE;
                endcase

                // Simultaneous push and pop keeps cnt; the new word lands
                // behind whatever survives the pop.
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0)
                            r_buf0 <= bus.fifo_rd_data;
                        else
                            r_buf1 <= bus.fifo_rd_data;
                        r_cnt <= r_cnt + 2'd1;
                    end
                    2'b01: begin
                        r_buf0 <= r_buf1;
                        r_cnt  <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_buf0 <= bus.fifo_rd_data;
                        end else begin
                            r_buf0 <= r_buf1;
                            r_buf1 <= bus.fifo_rd_data;
                        end
                    end
                    default: ;
                endcase

                if (w_serve)
                    r_sel <= ~r_sel;
            end
        end
    end

    // Registered pixel output and sticky flags (set beats clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb       <= '0;
            r_underflow <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (bus.pix_req)
                r_rgb <= w_serve ? w_pix : UNDERFLOW_COLOR;

            if (w_uf_set)
                r_underflow <= 1'b1;
            else if (clr)
                r_underflow <= 1'b0;

            if (w_fe_set)
                r_frame_err <= 1'b1;
            else if (clr)
                r_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pix_feeder.sv
// Directed bench for vga_pix_feeder with FRAME_PIX = 8 and a distinctive
// underflow colour. A behavioural standard FIFO feeds words whose pixels
// are consecutive integers, so the expected rgb sequence is just a count.
module tb_vga_pix_feeder;

    localparam logic [23:0] UFC = 24'hF00F00;

    logic clk;
    logic rst_n;
    logic en;
    logic clr;
    logic underflow;
    logic frame_err;

    vga_pix_feeder_if ifc ();

    vga_pix_feeder #(
        .FRAME_PIX      (8),
        .VS_ACTIVE      (1'b0),
        .UNDERFLOW_COLOR(UFC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .bus      (ifc.master),
        .underflow(underflow),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard (non-FWFT) FIFO model: data appears the cycle after rd_en.
    logic [63:0] mem [0:1023];
    logic [9:0]  wr_ptr = '0;
    logic [9:0]  rd_ptr = '0;

    assign ifc.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (ifc.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            ifc.fifo_rd_data <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 10'd1;
        end
    end

    int n_pass = 0;
    int n_tot  = 0;
    int lp     = 1;   // next pixel value to load into the FIFO
    int nxt    = 1;   // next pixel value expected on rgb_out

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tot++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = {8'h00, 24'(lp + 1), 8'h00, 24'(lp)};
            lp += 2;
            wr_ptr = wr_ptr + 10'd1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n back-to-back requests; each pixel checked the cycle after it is asked for.
    task automatic req_n(input string tag, input int n);
        ifc.pix_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, 64'(ifc.rgb_out), 64'(nxt));
            nxt++;
        end
        ifc.pix_req = 1'b0;
    endtask

    task automatic req_uf(input string tag);
        ifc.pix_req = 1'b1;
        @(negedge clk);
        check(tag, 64'(ifc.rgb_out), 64'(UFC));
        ifc.pix_req = 1'b0;
    endtask

    // One-cycle active-low vsync pulse; returns just after the sampling edge.
    task automatic vs_pulse(input logic with_clr);
        ifc.vsync = 1'b0;
        clr       = with_clr;
        @(negedge clk);
        ifc.vsync = 1'b1;
        clr       = 1'b0;
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        clr         = 1'b0;
        ifc.pix_req = 1'b0;
        ifc.vsync   = 1'b1;
        #3;
        check("rst_rgb",   64'(ifc.rgb_out),    64'h0);
        check("rst_rd_en", 64'(ifc.fifo_rd_en), 64'h0);
        check("rst_uf",    64'(underflow),      64'h0);
        check("rst_fe",    64'(frame_err),      64'h0);

        // Startup: two preloaded words, then vsync into RUN.
        @(negedge clk);
        rst_n = 1'b1;
        load(2);
        en = 1'b1;
        cycles(5);
        vs_pulse(1'b0);
        req_n("startup_pix", 4);
        check("startup_uf", 64'(underflow), 64'h0);

        // Underflow: FIFO drained after 4 pixels.
        req_uf("uf_color");
        check("uf_set", 64'(underflow), 64'h1);
        cycles(3);
        check("uf_sticky", 64'(underflow), 64'h1);
        clear_flags();
        check("uf_clr", 64'(underflow), 64'h0);

        // Throughput: 640 back-to-back requests with a well-stocked FIFO.
        load(320);
        cycles(4);
        req_n("thru_pix", 640);
        check("thru_uf", 64'(underflow), 64'h0);

        // 645 pixels since the RUN entry edge: long frame.
        vs_pulse(1'b0);
        check("fe_long", 64'(frame_err), 64'h1);
        clear_flags();
        check("fe_clr1", 64'(frame_err), 64'h0);

        // Exact frame of 8 pixels.
        load(4);
        cycles(4);
        req_n("f8_pix", 8);
        vs_pulse(1'b0);
        check("fe_exact", 64'(frame_err), 64'h0);

        // Short frame of 7 pixels.
        load(4);
        cycles(4);
        req_n("f7_pix", 7);
        vs_pulse(1'b0);
        check("fe_short", 64'(frame_err), 64'h1);
        clear_flags();
        check("fe_clr2", 64'(frame_err), 64'h0);

        // Short frame again, with clr on the same cycle as the edge.
        load(3);
        cycles(4);
        req_n("f7b_pix", 7);
        vs_pulse(1'b1);
        check("fe_set_wins", 64'(frame_err), 64'h1);
        clear_flags();
        check("fe_clr3", 64'(frame_err), 64'h0);

        // Flush: drop en while a read is in flight.
        load(4);
        cycles(4);
        req_n("flush_pre", 2);
        check("flush_rd_issue", 64'(ifc.fifo_rd_en), 64'h1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("flush_idle_rd_en", 64'(ifc.fifo_rd_en), 64'h0);
        req_uf("idle_req_color");
        check("idle_req_no_uf", 64'(underflow), 64'h0);
        en = 1'b1;
        load(1);
        cycles(5);
        vs_pulse(1'b0);
        nxt = 673;   // 669..672 were flushed or dropped in flight
        req_n("flush_post", 4);

        // Async reset mid-RUN with outputs non-zero.
        req_uf("pre_rst_color");
        vs_pulse(1'b0);
        load(1);
        #2;
        check("pre_rst_rd_en", 64'(ifc.fifo_rd_en), 64'h1);
        check("pre_rst_uf",    64'(underflow),      64'h1);
        check("pre_rst_fe",    64'(frame_err),      64'h1);
        rst_n = 1'b0;
        #1;
        check("arst_rgb",   64'(ifc.rgb_out),    64'h0);
        check("arst_rd_en", 64'(ifc.fifo_rd_en), 64'h0);
        check("arst_uf",    64'(underflow),      64'h0);
        check("arst_fe",    64'(frame_err),      64'h0);
        #4;
        rst_n = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
